// File: rtl/ram_arb_if.sv
// Bus bundle between two RAM requesters, the arbiter and a simple dual-port RAM.
// The arbiter takes the slave side; requesters plus RAM model take the master side.
interface ram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_raddr, ram_waddr, ram_we, ram_din,
    input  ram_dout
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_raddr, ram_waddr, ram_we, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_arb.sv
// Two-requester arbiter for a 1R1W RAM: independent round-robin arbitration of the
// read and write ports, read-after-write hazard stall, and a 1-cycle read return tag.
module ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic       clk,
  input logic       rst,
  ram_arb_if.slave  bus
);

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic                  a_wr, b_wr, a_rd, b_rd;
  logic                  wr_gnt, wr_sel;
  logic                  rd_any, rd_sel, rd_gnt, hazard;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  ptr_wr_q, ptr_wr_d;
  logic                  ptr_rd_q, ptr_rd_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  rd_own_p1_q, rd_own_p1_d;

  // Requests are masked by reset so nothing is granted while rst is high.
  always_comb begin
    a_wr = !rst && bus.a_req &&  bus.a_we;
    b_wr = !rst && bus.b_req &&  bus.b_we;
    a_rd = !rst && bus.a_req && !bus.a_we;
    b_rd = !rst && bus.b_req && !bus.b_we;
  end

  always_comb begin
    wr_gnt   = a_wr || b_wr;
    wr_sel   = b_wr;
    ptr_wr_d = ptr_wr_q;
    if (a_wr && b_wr) begin
      wr_sel   = ptr_wr_q;
      ptr_wr_d = ~ptr_wr_q;
    end
    wr_addr = (wr_sel == SEL_B) ? bus.b_addr  : bus.a_addr;
    wr_data = (wr_sel == SEL_B) ? bus.b_wdata : bus.a_wdata;
  end

  // A read colliding with this cycle's write is held off so it returns the new word.
  always_comb begin
    rd_any   = a_rd || b_rd;
    rd_sel   = b_rd;
    if (a_rd && b_rd) begin
      rd_sel = ptr_rd_q;
    end
    rd_addr  = (rd_sel == SEL_B) ? bus.b_addr : bus.a_addr;
    hazard   = rd_any && wr_gnt && (rd_addr == wr_addr);
    rd_gnt   = rd_any && !hazard;
    ptr_rd_d = ptr_rd_q;
    if (a_rd && b_rd && !hazard) begin
      ptr_rd_d = ~ptr_rd_q;
    end
  end

  always_comb begin
    waddr_d     = wr_gnt ? wr_addr : waddr_q;
    din_d       = wr_gnt ? wr_data : din_q;
    raddr_d     = rd_gnt ? rd_addr : raddr_q;
    rd_vld_p1_d = rd_gnt;
    rd_own_p1_d = rd_sel;
  end

  assign bus.a_gnt = (wr_gnt && (wr_sel == SEL_A) && a_wr) ||
                     (rd_gnt && (rd_sel == SEL_A) && a_rd);
  assign bus.b_gnt = (wr_gnt && (wr_sel == SEL_B) && b_wr) ||
                     (rd_gnt && (rd_sel == SEL_B) && b_rd);

  assign bus.ram_we    = wr_gnt;
  assign bus.ram_waddr = waddr_d;
  assign bus.ram_din   = din_d;
  assign bus.ram_raddr = raddr_d;

  // Stage p1: RAM output for the read granted last cycle, qualified by the tag.
  assign bus.a_rvalid = rd_vld_p1_q && (rd_own_p1_q == SEL_A);
  assign bus.b_rvalid = rd_vld_p1_q && (rd_own_p1_q == SEL_B);
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_wr_q    <= SEL_A;
      ptr_rd_q    <= SEL_A;
      raddr_q     <= '0;
      waddr_q     <= '0;
      din_q       <= '0;
      rd_vld_p1_q <= 1'b0;
      rd_own_p1_q <= SEL_A;
    end else begin
      ptr_wr_q    <= ptr_wr_d;
      ptr_rd_q    <= ptr_rd_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      din_q       <= din_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_own_p1_q <= rd_own_p1_d;
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed vector table, reset corner sequence, then random
// traffic checked against an arbitration-rule reference model with a shadow RAM.
module tb_ram_arb;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous 1R1W RAM: data appears one clock after the read address is sampled.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] dout_r = '0;
  assign bus.ram_dout = dout_r;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
    dout_r <= mem[bus.ram_raddr];
  end

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  typedef struct {
    logic a_req, a_we; logic [AW-1:0] a_addr; logic [DW-1:0] a_wdata;
    logic b_req, b_we; logic [AW-1:0] b_addr; logic [DW-1:0] b_wdata;
    logic e_agnt, e_bgnt, e_arv, e_brv; logic [DW-1:0] e_rdata;
    logic e_we; logic [AW-1:0] e_waddr; logic [DW-1:0] e_din; logic [AW-1:0] e_raddr;
  } vec_t;

  function automatic vec_t mkv(input int ar, input int aw, input int aa, input logic [DW-1:0] ad,
                               input int br, input int bw, input int ba, input logic [DW-1:0] bd,
                               input int ag, input int bg, input int arv, input int brv,
                               input logic [DW-1:0] rd, input int we, input int wa,
                               input logic [DW-1:0] din, input int ra);
    vec_t v;
    v.a_req = 1'(ar); v.a_we = 1'(aw); v.a_addr = AW'(aa); v.a_wdata = ad;
    v.b_req = 1'(br); v.b_we = 1'(bw); v.b_addr = AW'(ba); v.b_wdata = bd;
    v.e_agnt = 1'(ag); v.e_bgnt = 1'(bg); v.e_arv = 1'(arv); v.e_brv = 1'(brv); v.e_rdata = rd;
    v.e_we = 1'(we); v.e_waddr = AW'(wa); v.e_din = din; v.e_raddr = AW'(ra);
    return v;
  endfunction

  vec_t tbl [16];

  // Reference model state (0 = requester A, 1 = requester B).
  int            m_pw, m_pr, m_po;
  logic          m_pv;
  logic [DW-1:0] m_pd, m_ld;
  logic [AW-1:0] m_lr, m_lw;
  logic [DW-1:0] shadow [1<<AW];

  logic          rq [2];
  logic          wq [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic          eg [2];

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end

    //         ar aw aa  ad          br bw ba bd     ag bg arv brv rdata          we wa din          ra
    tbl[0]  = mkv(1,0, 5,0,          0,0, 0,0,       1,0,0,0,0,                   0, 0,0,          5);
    tbl[1]  = mkv(0,0, 0,0,          0,0, 0,0,       0,0,1,0,init_word(5),        0, 0,0,          5);
    tbl[2]  = mkv(1,0,10,0,          1,0,20,0,       1,0,0,0,0,                   0, 0,0,         10);
    tbl[3]  = mkv(1,0,10,0,          1,0,20,0,       0,1,1,0,init_word(10),       0, 0,0,         20);
    tbl[4]  = mkv(1,0,10,0,          1,0,20,0,       1,0,0,1,init_word(20),       0, 0,0,         10);
    tbl[5]  = mkv(1,0,10,0,          1,0,20,0,       0,1,1,0,init_word(10),       0, 0,0,         20);
    tbl[6]  = mkv(0,0, 0,0,          0,0, 0,0,       0,0,0,1,init_word(20),       0, 0,0,         20);
    tbl[7]  = mkv(1,1, 7,32'h1234,   1,0, 3,0,       1,1,0,0,0,                   1, 7,32'h1234,   3);
    tbl[8]  = mkv(0,0, 0,0,          0,0, 0,0,       0,0,0,1,init_word(3),        0, 7,32'h1234,   3);
    tbl[9]  = mkv(1,1, 9,32'hBEEF,   1,0, 9,0,       1,0,0,0,0,                   1, 9,32'hBEEF,   3);
    tbl[10] = mkv(0,0, 0,0,          1,0, 9,0,       0,1,0,0,0,                   0, 9,32'hBEEF,   9);
    tbl[11] = mkv(0,0, 0,0,          0,0, 0,0,       0,0,0,1,32'hBEEF,            0, 9,32'hBEEF,   9);
    tbl[12] = mkv(1,1,12,32'hA0,     1,1,13,32'hB0,  1,0,0,0,0,                   1,12,32'hA0,     9);
    tbl[13] = mkv(1,1,12,32'hA0,     1,1,13,32'hB0,  0,1,0,0,0,                   1,13,32'hB0,     9);
    tbl[14] = mkv(1,1,12,32'hA0,     1,1,13,32'hB0,  1,0,0,0,0,                   1,12,32'hA0,     9);
    tbl[15] = mkv(0,0, 0,0,          0,0, 0,0,       0,0,0,0,0,                   0,12,32'hA0,     9);

    drive(0,0,'0,'0, 0,0,'0,'0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Outputs while reset is held, with live requests on both sides.
    drive(1,0,AW'(5),'0, 1,1,AW'(6),32'h55);
    #1;
    check("rst a_gnt",     64'(bus.a_gnt),     64'(0));
    check("rst b_gnt",     64'(bus.b_gnt),     64'(0));
    check("rst ram_we",    64'(bus.ram_we),    64'(0));
    check("rst a_rvalid",  64'(bus.a_rvalid),  64'(0));
    check("rst b_rvalid",  64'(bus.b_rvalid),  64'(0));
    check("rst ram_raddr", 64'(bus.ram_raddr), 64'(0));
    check("rst ram_waddr", 64'(bus.ram_waddr), 64'(0));
    check("rst ram_din",   64'(bus.ram_din),   64'(0));

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].a_req, tbl[i].a_we, tbl[i].a_addr, tbl[i].a_wdata,
            tbl[i].b_req, tbl[i].b_we, tbl[i].b_addr, tbl[i].b_wdata);
      #1;
      check($sformatf("v%0d a_gnt", i),     64'(bus.a_gnt),     64'(tbl[i].e_agnt));
      check($sformatf("v%0d b_gnt", i),     64'(bus.b_gnt),     64'(tbl[i].e_bgnt));
      check($sformatf("v%0d a_rvalid", i),  64'(bus.a_rvalid),  64'(tbl[i].e_arv));
      check($sformatf("v%0d b_rvalid", i),  64'(bus.b_rvalid),  64'(tbl[i].e_brv));
      check($sformatf("v%0d ram_we", i),    64'(bus.ram_we),    64'(tbl[i].e_we));
      check($sformatf("v%0d ram_waddr", i), 64'(bus.ram_waddr), 64'(tbl[i].e_waddr));
      check($sformatf("v%0d ram_din", i),   64'(bus.ram_din),   64'(tbl[i].e_din));
      check($sformatf("v%0d ram_raddr", i), 64'(bus.ram_raddr), 64'(tbl[i].e_raddr));
      if (tbl[i].e_arv) check($sformatf("v%0d a_rdata", i), 64'(bus.a_rdata), 64'(tbl[i].e_rdata));
      if (tbl[i].e_brv) check($sformatf("v%0d b_rdata", i), 64'(bus.b_rdata), 64'(tbl[i].e_rdata));
    end

    // Reset arriving in the same cycle as a read grant; both pointers left at B first.
    @(negedge clk);
    drive(1,0,AW'(40),'0, 1,0,AW'(41),'0);
    #1;
    check("pre a_gnt", 64'(bus.a_gnt), 64'(1));
    check("pre b_gnt", 64'(bus.b_gnt), 64'(0));
    @(negedge clk);
    drive(1,0,AW'(42),'0, 0,0,'0,'0);
    #1;
    check("grant before rst", 64'(bus.a_gnt), 64'(1));
    rst = 1'b1;
    #1;
    check("async rst a_gnt",     64'(bus.a_gnt),     64'(0));
    check("async rst ram_raddr", 64'(bus.ram_raddr), 64'(0));
    check("async rst ram_waddr", 64'(bus.ram_waddr), 64'(0));
    check("async rst ram_din",   64'(bus.ram_din),   64'(0));
    @(negedge clk);
    drive(0,0,'0,'0, 0,0,'0,'0);
    rst = 1'b0;
    #1;
    check("post rst a_rvalid", 64'(bus.a_rvalid), 64'(0));
    check("post rst b_rvalid", 64'(bus.b_rvalid), 64'(0));
    @(negedge clk);
    drive(1,0,AW'(40),'0, 1,0,AW'(41),'0);
    #1;
    check("post rst rd a_gnt",   64'(bus.a_gnt),    64'(1));
    check("post rst rd b_gnt",   64'(bus.b_gnt),    64'(0));
    check("post rst rd a_rvalid",64'(bus.a_rvalid), 64'(0));
    check("post rst rd b_rvalid",64'(bus.b_rvalid), 64'(0));
    @(negedge clk);
    drive(1,1,AW'(50),32'h5050, 1,1,AW'(51),32'h5151);
    #1;
    check("post rst wr a_gnt",   64'(bus.a_gnt),     64'(1));
    check("post rst wr b_gnt",   64'(bus.b_gnt),     64'(0));
    check("post rst wr waddr",   64'(bus.ram_waddr), 64'(50));
    check("post rst rd a_rvalid",64'(bus.a_rvalid),  64'(1));
    check("post rst rd a_rdata", 64'(bus.a_rdata),   64'(init_word(40)));

    // Random traffic on addresses 32..35, untouched by the directed part above.
    @(negedge clk);
    drive(0,0,'0,'0, 0,0,'0,'0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pw = 0; m_pr = 0; m_po = 0; m_pv = 1'b0;
    m_pd = '0; m_ld = '0; m_lr = '0; m_lw = '0;
    for (int i = 0; i < 2; i++) rq[i] = 1'b0;

    for (int c = 0; c < 400; c++) begin
      int nw, nr, ww, rw;
      logic blk;
      for (int i = 0; i < 2; i++) begin
        if (!rq[i]) begin
          rq[i] = ($urandom_range(0, 3) != 0);
          wq[i] = 1'($urandom_range(0, 1));
          ad[i] = AW'(32 + $urandom_range(0, 3));
          wd[i] = $urandom;
        end
      end
      drive(rq[0], wq[0], ad[0], wd[0], rq[1], wq[1], ad[1], wd[1]);
      #1;

      nw = 0; nr = 0; ww = -1; rw = -1;
      for (int i = 0; i < 2; i++) begin
        if (rq[i] &&  wq[i]) nw++;
        if (rq[i] && !wq[i]) nr++;
      end
      if (nw == 2) begin
        ww = m_pw; m_pw = 1 - ww;
      end else if (nw == 1) begin
        ww = (rq[0] && wq[0]) ? 0 : 1;
      end
      if (nr == 2)      rw = m_pr;
      else if (nr == 1) rw = (rq[0] && !wq[0]) ? 0 : 1;
      blk = (rw >= 0) && (ww >= 0) && (ad[rw] == ad[ww]);
      if (blk)          rw = -1;
      else if (nr == 2) m_pr = 1 - rw;
      for (int i = 0; i < 2; i++) eg[i] = (i == ww) || (i == rw);

      check("rnd a_gnt",     64'(bus.a_gnt),     64'(eg[0]));
      check("rnd b_gnt",     64'(bus.b_gnt),     64'(eg[1]));
      check("rnd ram_we",    64'(bus.ram_we),    64'(ww >= 0));
      check("rnd ram_waddr", 64'(bus.ram_waddr), 64'((ww >= 0) ? ad[ww] : m_lw));
      check("rnd ram_din",   64'(bus.ram_din),   64'((ww >= 0) ? wd[ww] : m_ld));
      check("rnd ram_raddr", 64'(bus.ram_raddr), 64'((rw >= 0) ? ad[rw] : m_lr));
      check("rnd a_rvalid",  64'(bus.a_rvalid),  64'(m_pv && m_po == 0));
      check("rnd b_rvalid",  64'(bus.b_rvalid),  64'(m_pv && m_po == 1));
      if (m_pv && m_po == 0) check("rnd a_rdata", 64'(bus.a_rdata), 64'(m_pd));
      if (m_pv && m_po == 1) check("rnd b_rdata", 64'(bus.b_rdata), 64'(m_pd));

      m_pv = (rw >= 0);
      if (rw >= 0) begin
        m_po = rw;
        m_pd = shadow[ad[rw]];
        m_lr = ad[rw];
      end
      if (ww >= 0) begin
        shadow[ad[ww]] = wd[ww];
        m_lw = ad[ww];
        m_ld = wd[ww];
      end
      for (int i = 0; i < 2; i++) if (eg[i]) rq[i] = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of RAM data word.
REQ-002 Parameter ADDR_WIDTH, default 10, width of RAM word address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_req  input  1  requester A access request; held until granted.
REQ-006 a_we  input  1  requester A access type: 1 = write, 0 = read.
REQ-007 a_addr  input  ADDR_WIDTH  requester A word address.
REQ-008 a_wdata  input  DATA_WIDTH  requester A write data.
REQ-009 a_gnt  output  1  requester A access accepted this cycle.
REQ-010 a_rvalid  output  1  requester A read data valid.
REQ-011 a_rdata  output  DATA_WIDTH  requester A read data.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata SHALL match REQ-005..REQ-011 for requester B.
REQ-013 ram_raddr  output  ADDR_WIDTH  to RAM read address.
REQ-014 ram_waddr  output  ADDR_WIDTH  to RAM write address.
REQ-015 ram_we  output  1  to RAM write enable.
REQ-016 ram_din  output  DATA_WIDTH  to RAM write data.
REQ-017 ram_dout  input  DATA_WIDTH  from RAM; valid one clock after ram_raddr is sampled.

Function
REQ-018 Read port and write port SHALL be arbitrated independently; one read and one write SHALL be grantable in the same cycle.
REQ-019 x_gnt SHALL be combinational from the current inputs and arbiter state; an access completes in the cycle where x_req and x_gnt are both high.
REQ-020 Write arbitration: among requesters with req=1 and we=1, one winner per cycle; ram_we=1, ram_waddr and ram_din from the winner in that cycle.
REQ-021 Read arbitration: among requesters with req=1 and we=0, one winner per cycle; ram_raddr from the winner in that cycle.
REQ-022 Each port SHALL have a 1-bit round-robin pointer naming the preferred requester; on contention the preferred one wins and the pointer SHALL then point at the loser.
REQ-023 Without contention the sole requester wins and its port pointer SHALL remain unchanged.
REQ-024 Hazard: if the read winner address equals the write winner address in the same cycle, the read SHALL NOT be granted; the write proceeds; the read is retried next cycle and returns the new data.
REQ-025 A read held back by REQ-024 SHALL NOT advance the read pointer.
REQ-026 A registered 2-bit read tag (valid, owner) SHALL record each read grant; in the following cycle x_rvalid=1 for the owner only, x_rdata = ram_dout.
REQ-027 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back reads SHALL sustain one per cycle.
REQ-028 x_rdata SHALL be driven from ram_dout at all times; only x_rvalid qualifies it.
REQ-029 When no write is granted, ram_we=0 and ram_waddr/ram_din hold the last granted values.
REQ-030 When no read is granted, ram_raddr SHALL hold the last granted read address.
REQ-031 Inputs x_we, x_addr and x_wdata are sampled only while x_req=1.

Reset
REQ-032 While rst=1: a_gnt=b_gnt=0, ram_we=0, a_rvalid=b_rvalid=0; both round-robin pointers = A; read tag invalid; ram_raddr/ram_waddr/ram_din = 0.
REQ-033 A read granted in the cycle rst asserts SHALL NOT produce rvalid after rst deasserts.
REQ-034 The first rising edge after rst deasserts SHALL be a normal arbitration cycle.

Verification
REQ-035 A read addr 5 alone -> a_gnt=1 same cycle, a_rvalid=1 next cycle with RAM word 5, b_rvalid=0.
REQ-036 A and B both read every cycle for 4 cycles, from reset -> grants A,B,A,B; rvalid follows 1 cycle later in that order.
REQ-037 A write addr 7 data 0x1234 and B read addr 3 same cycle -> both granted; b_rvalid next cycle with word 3.
REQ-038 A write addr 9 data 0xBEEF and B read addr 9 same cycle -> only a_gnt; B granted next cycle; b_rdata=0xBEEF.
REQ-039 Both write contending 3 cycles -> write grants A,B,A; ram_we=1 each cycle with winner's waddr/din.
REQ-040 rst asserted in the cycle a read is granted -> no rvalid after release; pointers = A; first contention goes to A.
